conv3x3_stream: RTL and testbench

- Downstream consumer of the 8-bit, 512-deep pixel FIFO (normal mode: q valid the cycle after rdreq).
- Pops a raster-order frame of unsigned 8-bit pixels and forms a 3x3 sliding window from two line buffers.
- Applies a signed 3x3 kernel, "valid" mode only (no padding), and emits one saturated 8-bit result per interior pixel over a valid/ready handshake.

---
 rtl/conv3x3_stream_if.sv | 28 ++
 rtl/conv3x3_stream.sv | 171 +++++++++++++++++
 tb/tb_conv3x3_stream.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/conv3x3_stream_if.sv
// Stream bundle for conv3x3_stream: pixel FIFO read side plus result valid/ready output.
// master = the convolution block, slave = the FIFO/consumer environment.
interface conv3x3_stream_if;
  logic [7:0] fifo_q;
  logic       fifo_empty;
  logic       fifo_rdreq;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;

  modport master (
    input  fifo_q,
    input  fifo_empty,
    input  out_ready,
    output fifo_rdreq,
    output out_data,
    output out_valid
  );

  modport slave (
    output fifo_q,
    output fifo_empty,
    output out_ready,
    input  fifo_rdreq,
    input  out_data,
    input  out_valid
  );
endinterface

// File: rtl/conv3x3_stream.sv
// 3x3 "valid"-mode convolution over a raster-order 8-bit pixel stream popped from a FIFO.
// Two line buffers hold the previous two rows; one saturated 8-bit result is produced per
// interior pixel through a valid/ready output register.
module conv3x3_stream #(
  parameter int unsigned IMG_W = 64,
  parameter int unsigned IMG_H = 64,
  parameter int unsigned SHIFT = 0
) (
  input  logic             clock,
  input  logic             sclr,
  input  logic             start,
  input  logic [71:0]      coef,
  conv3x3_stream_if.master strm,
  output logic             busy,
  output logic             done
);

  localparam int unsigned NumPix   = IMG_W * IMG_H;
  localparam int unsigned XWidth   = $clog2(IMG_W);
  localparam int unsigned YWidth   = $clog2(IMG_H);
  localparam int unsigned CntWidth = $clog2(NumPix + 1);

  typedef enum logic [1:0] {StIdle, StRun, StFlush} state_e;

  state_e                r_state;
  logic [XWidth-1:0]     r_x;
  logic [YWidth-1:0]     r_y;
  logic [CntWidth-1:0]   r_issued;
  logic                  r_rd_pending;
  logic [71:0]           r_coef;
  logic [7:0]            r_win [3][3];
  logic [7:0]            r_lb0 [IMG_W];
  logic [7:0]            r_lb1 [IMG_W];
  logic [7:0]            r_out_data;
  logic                  r_out_valid;

  logic                  w_rdreq;
  logic                  w_accept;
  logic                  w_capture;
  logic                  w_interior;
  logic                  w_last_col;
  logic [7:0]            w_col [3];
  logic [7:0]            w_win [3][3];
  logic signed [16:0]    w_prod [9];
  logic signed [20:0]    w_sum;
  logic signed [20:0]    w_shifted;
  logic [7:0]            w_result;

  // Pixel (zero-extended) times signed tap, both widened to the 17-bit product width.
  function automatic logic signed [16:0] mul_tap(input logic [7:0] pix, input logic [7:0] tap);
    logic signed [16:0] a;
    logic signed [16:0] b;
    a = signed'({9'd0, pix});
    b = signed'({{9{tap[7]}}, tap});
    return a * b;
  endfunction

  // Only one read in flight, and never one that could land on an unaccepted result.
  assign w_rdreq    = (r_state == StRun) && !strm.fifo_empty &&
                      (r_issued < CntWidth'(NumPix)) && !r_rd_pending &&
                      (!r_out_valid || strm.out_ready);
  assign w_accept   = r_out_valid && strm.out_ready;
  assign w_capture  = r_rd_pending;
  assign w_interior = (r_x >= XWidth'(2)) && (r_y >= YWidth'(2));
  assign w_last_col = (r_x == XWidth'(IMG_W - 1));

  // Next window: shift left, new right column = {lb1[x], lb0[x], fifo_q} (oldest row first).
  always_comb begin
    w_col[0] = r_lb1[r_x];
    w_col[1] = r_lb0[r_x];
    w_col[2] = strm.fifo_q;
    for (int r = 0; r < 3; r++) begin
      w_win[r][0] = r_win[r][1];
      w_win[r][1] = r_win[r][2];
      w_win[r][2] = w_col[r];
    end
  end

  // Nine-tap MAC on the next window, arithmetic shift, then clamp to 0..255.
  always_comb begin
    w_sum = '0;
    for (int k = 0; k < 9; k++) begin
      w_prod[k] = mul_tap(w_win[k/3][k%3], r_coef[8*k +: 8]);
      w_sum     = w_sum + {{4{w_prod[k][16]}}, w_prod[k]};
    end
    w_shifted = w_sum >>> SHIFT;
    if (w_shifted[20]) begin
      w_result = 8'd0;
    end else if (w_shifted > 21'sd255) begin
      w_result = 8'd255;
    end else begin
      w_result = w_shifted[7:0];
    end
  end

  // Control FSM, position counters and the output register.
  always_ff @(posedge clock) begin
    if (sclr) begin
      r_state      <= StIdle;
      r_x          <= '0;
      r_y          <= '0;
      r_issued     <= '0;
      r_rd_pending <= 1'b0;
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
    end else begin
      case (r_state)
        StIdle: begin
          if (start) begin
            r_state      <= StRun;
            r_x          <= '0;
            r_y          <= '0;
            r_issued     <= '0;
            r_rd_pending <= 1'b0;
          end
        end
        StRun: begin
          r_rd_pending <= w_rdreq;
          if (w_rdreq) begin
            r_issued <= r_issued + CntWidth'(1);
          end
          if (w_capture) begin
            if (w_last_col) begin
              r_x <= '0;
              r_y <= r_y + YWidth'(1);
            end else begin
              r_x <= r_x + XWidth'(1);
            end
            // issued already counts this pixel, so equality means the frame is fully read
            if (r_issued == CntWidth'(NumPix)) begin
              r_state <= StFlush;
            end
          end
        end
        StFlush: begin
          if (!r_out_valid || strm.out_ready) begin
            r_state <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase

      // Read gating guarantees the register is empty or draining whenever a result loads.
      if (w_capture && w_interior) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_result;
      end else if (w_accept) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  // Datapath storage without reset: kernel snapshot, window and line buffers.
  always_ff @(posedge clock) begin
    if (!sclr && (r_state == StIdle) && start) begin
      r_coef <= coef;
    end
    if (w_capture) begin
      r_win       <= w_win;
      r_lb1[r_x]  <= r_lb0[r_x];
      r_lb0[r_x]  <= strm.fifo_q;
    end
  end

  assign strm.fifo_rdreq = w_rdreq;
  assign strm.out_data   = r_out_data;
  assign strm.out_valid  = r_out_valid;
  assign busy            = (r_state != StIdle);
  assign done            = (r_state == StFlush) && (!r_out_valid || strm.out_ready);

endmodule

// File: tb/tb_conv3x3_stream.sv
// Bench for conv3x3_stream: two instances (4x4 unshifted, 5x4 with SHIFT=3) fed from a
// behavioural FIFO, results scored against a direct 3x3 convolution of the frame.
module tb_conv3x3_stream;

  localparam int unsigned W0 = 4;
  localparam int unsigned H0 = 4;
  localparam int unsigned W1 = 5;
  localparam int unsigned H1 = 4;
  localparam int unsigned S1 = 3;

  logic        clk = 1'b0;
  logic        sclr;
  logic        start0, start1;
  logic [71:0] coef0, coef1;
  logic        busy0, done0, busy1, done1;
  logic        gap, rdy, fifo_clr, sel, mon_en;

  int          pix [1024];
  int          wr_n;
  int          rp0, rp1;
  int          exp_q [$];
  int          ei, done_cnt, rd_cnt, rdk_cyc, fv_cyc, cyc, cur_w;
  bit          fv_seen, stall_prev;
  int          stall_data;
  int          n_vec = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  conv3x3_stream_if bus0 ();
  conv3x3_stream_if bus1 ();

  conv3x3_stream #(.IMG_W(W0), .IMG_H(H0), .SHIFT(0)) u_dut0 (
    .clock (clk),
    .sclr  (sclr),
    .start (start0),
    .coef  (coef0),
    .strm  (bus0),
    .busy  (busy0),
    .done  (done0)
  );

  conv3x3_stream #(.IMG_W(W1), .IMG_H(H1), .SHIFT(S1)) u_dut1 (
    .clock (clk),
    .sclr  (sclr),
    .start (start1),
    .coef  (coef1),
    .strm  (bus1),
    .busy  (busy1),
    .done  (done1)
  );

  // Normal-mode FIFO: q is valid the cycle after rdreq.
  always @(posedge clk) begin
    if (fifo_clr) begin
      rp0 <= 0;
      rp1 <= 0;
    end else begin
      if (bus0.fifo_rdreq) begin
        bus0.fifo_q <= 8'(pix[rp0]);
        rp0         <= rp0 + 1;
      end
      if (bus1.fifo_rdreq) begin
        bus1.fifo_q <= 8'(pix[rp1]);
        rp1         <= rp1 + 1;
      end
    end
  end

  assign bus0.fifo_empty = (rp0 >= wr_n) || gap;
  assign bus1.fifo_empty = (rp1 >= wr_n) || gap;
  assign bus0.out_ready  = rdy;
  assign bus1.out_ready  = rdy;

  wire       m_rdreq = sel ? bus1.fifo_rdreq : bus0.fifo_rdreq;
  wire       m_empty = sel ? bus1.fifo_empty : bus0.fifo_empty;
  wire       m_valid = sel ? bus1.out_valid  : bus0.out_valid;
  wire [7:0] m_data  = sel ? bus1.out_data   : bus0.out_data;
  wire       m_done  = sel ? done1 : done0;
  wire       m_busy  = sel ? busy1 : busy0;

  task automatic chk(input string tag, input int got, input int want);
    n_vec++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, want, $time);
    end
  endtask

  // Reference: every centre (cx,cy) with a full 3x3 neighbourhood, raster order.
  task automatic build_exp(input int w, input int h, input int sh, input logic [71:0] cf);
    exp_q.delete();
    for (int cy = 1; cy < h - 1; cy++) begin
      for (int cx = 1; cx < w - 1; cx++) begin
        int acc;
        logic [7:0] tap;
        acc = 0;
        for (int k = 0; k < 9; k++) begin
          tap = cf[8*k +: 8];
          acc += int'($signed(tap)) * pix[(cy + k/3 - 1) * w + cx + k%3 - 1];
        end
        acc = acc >>> sh;
        exp_q.push_back(acc < 0 ? 0 : (acc > 255 ? 255 : acc));
      end
    end
  endtask

  // mode 0: ramp 0,1,2..  mode 1: constant v  mode 2: random 0..v
  task automatic fill(input int mode, input int n, input int v);
    for (int i = 0; i < n; i++) begin
      pix[i] = (mode == 0) ? i : (mode == 1) ? v : int'($urandom_range(v));
    end
  endtask

  function automatic logic [71:0] taps_all(input int v);
    logic [71:0] cf;
    for (int k = 0; k < 9; k++) cf[8*k +: 8] = 8'(v);
    return cf;
  endfunction

  function automatic logic [71:0] taps_rand(input int m);
    logic [71:0] cf;
    for (int k = 0; k < 9; k++) cf[8*k +: 8] = 8'(int'($urandom_range(2 * m)) - m);
    return cf;
  endfunction

  // Monitor: scoreboard, stall stability, read gating and first-result latency.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (mon_en) begin
        if (m_rdreq) begin
          rd_cnt++;
          // read of pixel (2,2), the first interior position
          if (rd_cnt == 2 * cur_w + 3) rdk_cyc = cyc;
        end
        if (m_empty) chk("rdreq_while_empty", int'(m_rdreq), 0);
        if (m_valid && !fv_seen) begin
          fv_seen = 1'b1;
          fv_cyc  = cyc;
        end
        if (stall_prev) begin
          chk("stall_valid_held", int'(m_valid), 1);
          chk("stall_data_stable", int'(m_data), stall_data);
        end
        if (m_valid && !rdy) begin
          chk("stall_no_rdreq", int'(m_rdreq), 0);
          stall_prev = 1'b1;
          stall_data = int'(m_data);
        end else begin
          stall_prev = 1'b0;
        end
        if (m_valid && rdy) begin
          if (ei < exp_q.size()) chk("out_data", int'(m_data), exp_q[ei]);
          else                   chk("extra_out", ei, exp_q.size());
          ei++;
        end
        if (m_done) begin
          done_cnt++;
          chk("done_at_last", ei, exp_q.size());
        end
      end
    end
  end

  // rdy_mode 0: always ready, 1: random, 2: hold low for 10 cycles at first valid.
  task automatic run_frame(input bit s, input logic [71:0] cf, input int gap_pct,
                           input int rdy_mode, input bit poke);
    int t, w, h, sh, bp;
    w = s ? W1 : W0;
    h = s ? H1 : H0;
    sh = s ? S1 : 0;
    sel = s;
    cur_w = w;
    build_exp(w, h, sh, cf);
    wr_n = w * h;
    fifo_clr = 1'b1;
    @(posedge clk); #1;
    fifo_clr = 1'b0;
    ei = 0; done_cnt = 0; rd_cnt = 0; rdk_cyc = -100; fv_cyc = 0;
    fv_seen = 1'b0; stall_prev = 1'b0;
    if (s) begin coef1 = cf; start1 = 1'b1; end
    else   begin coef0 = cf; start0 = 1'b1; end
    mon_en = 1'b1;
    t = 0;
    bp = 0;
    @(posedge clk); #1;
    while (done_cnt == 0 && t < 3000) begin
      start0 = 1'b0;
      start1 = 1'b0;
      gap = ($urandom_range(99) < gap_pct);
      case (rdy_mode)
        0: rdy = 1'b1;
        1: rdy = 1'($urandom_range(1));
        default: begin
          if (m_valid && bp < 10) begin
            rdy = 1'b0;
            bp++;
          end else begin
            rdy = 1'b1;
          end
        end
      endcase
      // kernel input wiggles mid-frame; the latched copy must be used
      if (t == 4) begin
        if (s) coef1 = taps_rand(100);
        else   coef0 = taps_rand(100);
      end
      if (poke && t == 6) begin
        if (s) start1 = 1'b1;
        else   start0 = 1'b1;
      end
      @(posedge clk); #1;
      t++;
    end
    start0 = 1'b0;
    start1 = 1'b0;
    gap = 1'b0;
    rdy = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("done_pulses", done_cnt, 1);
    chk("out_count", ei, exp_q.size());
    chk("first_valid_latency", fv_cyc - rdk_cyc, 2);
    chk("pixels_read", rd_cnt, w * h);
    chk("busy_after", int'(m_busy), 0);
    mon_en = 1'b0;
  endtask

  initial begin
    sclr = 1'b1; start0 = 1'b1; start1 = 1'b1; coef0 = '0; coef1 = '0;
    gap = 1'b0; rdy = 1'b1; fifo_clr = 1'b1; sel = 1'b0; mon_en = 1'b0;
    wr_n = 16; cyc = 0; cur_w = W0;
    fill(0, 16, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rdreq0", int'(bus0.fifo_rdreq), 0);
    chk("rst_valid0", int'(bus0.out_valid), 0);
    chk("rst_data0", int'(bus0.out_data), 0);
    chk("rst_busy0", int'(busy0), 0);
    chk("rst_done0", int'(done0), 0);
    chk("rst_busy1", int'(busy1), 0);
    chk("rst_valid1", int'(bus1.out_valid), 0);
    sclr = 1'b0; start0 = 1'b0; start1 = 1'b0; fifo_clr = 1'b0;
    @(posedge clk); #1;

    // Identity on ramp (5,6,9,10) with a stray start while running.
    fill(0, 16, 0);
    run_frame(1'b0, 72'h01 << 32, 0, 0, 1'b1);
    // Identity with a 10-cycle consumer stall.
    run_frame(1'b0, 72'h01 << 32, 0, 2, 1'b0);
    // Underflow gaps on random pixels.
    fill(2, 16, 255);
    run_frame(1'b0, 72'h01 << 32, 50, 0, 1'b0);
    // Saturation both ways.
    fill(1, 16, 100);
    run_frame(1'b0, taps_all(1), 0, 0, 1'b0);
    run_frame(1'b0, taps_all(-1), 20, 1, 1'b0);

    // Abort mid-frame, then a fresh frame.
    sel = 1'b0;
    fill(0, 16, 0);
    wr_n = 16;
    fifo_clr = 1'b1;
    @(posedge clk); #1;
    fifo_clr = 1'b0;
    coef0 = 72'h01 << 32;
    start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    repeat (24) begin @(posedge clk); #1; end
    rdy = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    sclr = 1'b1;
    @(posedge clk); #1;
    chk("abort_rdreq", int'(bus0.fifo_rdreq), 0);
    chk("abort_valid", int'(bus0.out_valid), 0);
    chk("abort_data", int'(bus0.out_data), 0);
    chk("abort_busy", int'(busy0), 0);
    chk("abort_done", int'(done0), 0);
    sclr = 1'b0;
    rdy = 1'b1;
    run_frame(1'b0, 72'h01 << 32, 0, 0, 1'b0);

    // Random kernels and pixels with gaps and backpressure.
    repeat (4) begin
      fill(2, 16, 63);
      run_frame(1'b0, taps_rand(2), 30, 1, 1'b1);
    end
    fill(2, 16, 255);
    run_frame(1'b0, taps_rand(127), 30, 1, 1'b0);

    // Shifted instance: constant 8 with unit taps gives 72>>3 = 9, then random frames.
    fill(1, 20, 8);
    run_frame(1'b1, taps_all(1), 0, 0, 1'b0);
    repeat (2) begin
      fill(2, 20, 255);
      run_frame(1'b1, taps_rand(8), 30, 1, 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
